// File: rtl/ucrv32_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, out-of-range read value and
// default geometry.
package ucrv32_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
    localparam int unsigned DEFAULT_LATENCY     = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory: synchronous byte-lane write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array
    import ucrv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       wmask,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: stores complete in one cycle, loads return after a
// fixed latency through a valid/ready response channel.
module dmem_responder
    import ucrv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic        dmem_req_write,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_wdata,
    input  logic [3:0]  dmem_req_wmask,
    output logic        dmem_resp_valid,
    input  logic        dmem_resp_ready,
    output logic [31:0] dmem_resp_rdata,
    output logic        addr_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    dmem_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             oor_q, oor_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [31:0]      rd_cnt_q, rd_cnt_d;
    logic [31:0]      wr_cnt_q, wr_cnt_d;
    logic             init_q;

    logic [IDX_W-1:0] req_idx, rd_idx;
    logic             req_oor, rd_oor, accept, arr_we;
    logic [31:0]      arr_rdata, load_word;

    assign req_idx = dmem_req_addr[IDX_W+1:2];
    assign req_oor = (dmem_req_addr >> (IDX_W + 2)) != 32'd0;
    assign accept  = dmem_req_valid && dmem_req_ready;
    assign arr_we  = accept && dmem_req_write && !req_oor;

    // With LATENCY=1 the response word is captured at the acceptance edge itself.
    assign rd_idx    = (state_q == StIdle) ? req_idx : idx_q;
    assign rd_oor    = (state_q == StIdle) ? req_oor : oor_q;
    assign load_word = rd_oor ? OOR_RDATA : arr_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wmask (dmem_req_wmask),
        .widx  (req_idx),
        .wdata (dmem_req_wdata),
        .ridx  (rd_idx),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d = err_q | req_oor;
                    if (dmem_req_write) begin
                        wr_cnt_d = wr_cnt_q + 32'd1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 32'd1;
                        idx_d    = req_idx;
                        oor_d    = req_oor;
                        if (LATENCY <= 1) begin
                            state_d = StResp;
                            rdata_d = load_word;
                        end else begin
                            state_d = StWait;
                            cnt_d   = LAT_M1;
                        end
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StResp;
                    rdata_d = load_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (dmem_resp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            init_q   <= 1'b1;
        end
    end

    assign dmem_req_ready  = init_q && (state_q == StIdle);
    assign dmem_resp_valid = (state_q == StResp);
    assign dmem_resp_rdata = (state_q == StResp) ? rdata_q : 32'd0;
    assign addr_err        = err_q;
    assign rd_count        = rd_cnt_q;
    assign wr_count        = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main sequences, LATENCY=1
// instance for back-to-back stores with single-cycle reads.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        req_ready, resp_valid, addr_err;
    logic [31:0] resp_rdata, rd_count, wr_count;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b1;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_wmask = '0;
    logic        b_req_ready, b_resp_valid, b_addr_err;
    logic [31:0] b_resp_rdata, b_rd_count, b_wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .dmem_req_valid  (req_valid),
        .dmem_req_ready  (req_ready),
        .dmem_req_write  (req_write),
        .dmem_req_addr   (req_addr),
        .dmem_req_wdata  (req_wdata),
        .dmem_req_wmask  (req_wmask),
        .dmem_resp_valid (resp_valid),
        .dmem_resp_ready (resp_ready),
        .dmem_resp_rdata (resp_rdata),
        .addr_err        (addr_err),
        .rd_count        (rd_count),
        .wr_count        (wr_count)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk             (clk),
        .resetn          (resetn),
        .dmem_req_valid  (b_req_valid),
        .dmem_req_ready  (b_req_ready),
        .dmem_req_write  (b_req_write),
        .dmem_req_addr   (b_req_addr),
        .dmem_req_wdata  (b_req_wdata),
        .dmem_req_wmask  (b_req_wmask),
        .dmem_resp_valid (b_resp_valid),
        .dmem_resp_ready (b_resp_ready),
        .dmem_resp_rdata (b_resp_rdata),
        .addr_err        (b_addr_err),
        .rd_count        (b_rd_count),
        .wr_count        (b_wr_count)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input logic exp_err,
                        input int hold, input string name);
        int n = 1;
        int bad = 0;
        logic [31:0] held;
        resp_ready = (hold == 0);
        req(1'b0, a, 32'd0, 4'd0);
        chk("resp_valid_early", {31'd0, resp_valid}, 32'd0);
        chk("rdata_zero_when_invalid", resp_rdata, 32'd0);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("load_latency", n, 32'd2);
        chk(name, resp_rdata, exp);
        chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        for (int k = 0; k < hold; k++) begin
            held = resp_rdata;
            @(negedge clk);
            if (resp_rdata !== held || req_ready !== 1'b0 || resp_valid !== 1'b1) bad++;
        end
        if (hold > 0) chk("resp_hold_stable", bad, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
        chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   seen;

        vecs[0] = '{1'b1, 32'h20, 32'h1122_3344, 4'b1111, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h20, 32'h5555_5555, 4'b0100, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h20, 32'h0,         4'b0000, 32'h1155_3344, 1'b0};
        vecs[3] = '{1'b1, 32'h30, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 32'h00, 32'h0102_0304, 4'b1111, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 32'h10, 32'h0000_0000, 4'b0000, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 32'h1000, 32'h0,       4'b0000, 32'h0, 1'b1};
        vecs[7] = '{1'b1, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1};
        vecs[8] = '{1'b0, 32'h00, 32'h0,         4'b0000, 32'h0102_0304, 1'b1};
        vecs[9] = '{1'b0, 32'h10, 32'h0,         4'b0000, 32'hAABB_CCDD, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_rd_count", rd_count, 32'd0);
        chk("rst_wr_count", wr_count, 32'd0);
        resetn = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_first_edge", {31'd0, req_ready}, 32'd1);

        // Full-word store then load.
        req(1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
        load(32'h10, 32'hAABB_CCDD, 1'b0, 0, "load_0x10");
        chk("wr_count_1", wr_count, 32'd1);
        chk("rd_count_1", rd_count, 32'd1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].write) begin
                req(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            end else begin
                load(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err, 0,
                     $sformatf("vec%0d_rdata", i));
            end
        end
        chk("wr_count_table", wr_count, 32'd7);
        chk("rd_count_table", rd_count, 32'd5);

        // Response back-pressure for 5 cycles.
        load(32'h30, 32'hCAFE_F00D, 1'b1, 5, "load_0x30_held");
        chk("rd_count_held", rd_count, 32'd6);

        // Reset while a load is in WAIT.
        req(1'b0, 32'h10, 32'd0, 4'd0);
        resetn = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("midrst_rd_count", rd_count, 32'd0);
        chk("midrst_wr_count", wr_count, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("no_resp_after_reset", seen, 32'd0);
        chk("post_rst_rd_count", rd_count, 32'd0);
        chk("post_rst_wr_count", wr_count, 32'd0);
        load(32'h10, 32'hAABB_CCDD, 1'b0, 0, "mem_kept_across_reset");

        // LATENCY=1 instance: four back-to-back stores, then single-cycle reads.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_ready_store%0d", i), {31'd0, b_req_ready}, 32'd1);
            b_req_valid = 1'b1;
            b_req_write = 1'b1;
            b_req_addr  = 32'(4 * i);
            b_req_wdata = 32'hA0B0_C000 + 32'(i);
            b_req_wmask = 4'b1111;
            @(posedge clk);
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        chk("b_wr_count", b_wr_count, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_ready_load%0d", i), {31'd0, b_req_ready}, 32'd1);
            b_req_valid = 1'b1;
            b_req_write = 1'b0;
            b_req_addr  = 32'(4 * i);
            @(posedge clk);
            @(negedge clk);
            b_req_valid = 1'b0;
            chk($sformatf("b_valid_next_cycle%0d", i), {31'd0, b_resp_valid}, 32'd1);
            chk($sformatf("b_rdata%0d", i), b_resp_rdata, 32'hA0B0_C000 + 32'(i));
            @(negedge clk);
            chk($sformatf("b_valid_done%0d", i), {31'd0, b_resp_valid}, 32'd0);
        end
        chk("b_rd_count", b_rd_count, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit memory words; power of two.
REQ-002 Parameter LATENCY, default 2: read acceptance-to-response delay in cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 dmem_req_valid  input  1  request present.
REQ-006 dmem_req_ready  output  1  responder can accept a request this cycle.
REQ-007 dmem_req_write  input  1  1 = store, 0 = load.
REQ-008 dmem_req_addr  input  32  byte address; bits [1:0] ignored for word selection.
REQ-009 dmem_req_wdata  input  32  store data, already lane-replicated by the initiator.
REQ-010 dmem_req_wmask  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 dmem_resp_valid  output  1  load data valid.
REQ-012 dmem_resp_ready  input  1  initiator accepts the response.
REQ-013 dmem_resp_rdata  output  32  full aligned word; the initiator performs byte/half extraction.
REQ-014 addr_err  output  1  sticky flag, set by any out-of-range access.
REQ-015 rd_count, wr_count  output  32 each  accepted loads/stores since reset; wrap modulo 2^32.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 dmem_req_ready is 1 only in IDLE.
REQ-018 A request is accepted on a rising edge where dmem_req_valid and dmem_req_ready are both 1.
REQ-019 Accepted store: write only the lanes set in wmask, in the same edge; no response is generated; FSM stays IDLE; ready stays 1, so back-to-back stores proceed one per cycle.
REQ-020 Accepted store with wmask = 0: no memory change; wr_count still increments.
REQ-021 Accepted load: capture the word address and load the down-counter with LATENCY-1. If LATENCY=1, go directly to RESP; otherwise go to WAIT.
REQ-022 WAIT: decrement the counter each cycle and go to RESP when it reaches 0. dmem_resp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-023 RESP: dmem_resp_valid=1 and dmem_resp_rdata is held stable until an edge with dmem_resp_ready=1. At that edge, return to IDLE. No new request is accepted at that same edge.
REQ-024 Read data is the array content at the moment of entry to RESP. Because only one transaction is outstanding, a load always observes all previously accepted stores.
REQ-025 dmem_resp_rdata is 0 whenever dmem_resp_valid is 0.
REQ-026 Word index is addr[log2(DEPTH_WORDS)+1:2]. Any set bit above this range marks the access out of range:
- out-of-range loads return 32'h0000_0000 with normal timing;
- out-of-range stores are dropped;
- both set addr_err.
REQ-027 Counters increment at the acceptance edge, whether or not the access is in range.

Reset
REQ-028 resetn low immediately forces: FSM to IDLE, dmem_req_ready=0, dmem_resp_valid=0, dmem_resp_rdata=0, addr_err=0, rd_count=0, wr_count=0, latency counter=0.
REQ-029 dmem_req_ready goes to 1 on the first rising edge after resetn deasserts.
REQ-030 Reset during WAIT or RESP discards the pending response; no response is emitted after reset.
REQ-031 Memory array contents are not reset and are preserved across reset.

Structure
REQ-032 Shared package ucrv32_mem_pkg holds:
- FSM state encoding (IDLE=0, WAIT=1, RESP=2);
- OOR_RDATA = 32'h0;
- default DEPTH_WORDS and LATENCY.
REQ-033 One sub-module, dmem_array: synchronous-write, asynchronous-read word array with 4-lane byte write enable. All other logic lives in dmem_responder.

Verification
REQ-034 Store addr 0x10, wdata 0xAABBCCDD, wmask 4'b1111; then load 0x10 with LATENCY=2 -> resp_valid high exactly 2 cycles after load accept; rdata=0xAABBCCDD; wr_count=1, rd_count=1.
REQ-035 Memory at 0x20 holds 0x11223344. Store wdata 0x55555555, wmask 4'b0100, then load 0x20 -> rdata=0x11553344.
REQ-036 Load 0x30 with resp_ready held low 5 cycles after resp_valid -> rdata stable, req_ready=0 throughout; after the handshake, req_ready=1 the next cycle.
REQ-037 With DEPTH_WORDS=1024, load 0x0000_1000 -> rdata=0, addr_err=1. Then store to 0x1000 -> array word 0 unchanged.
REQ-038 Assert resetn low mid-WAIT, release, then idle 10 cycles -> resp_valid never asserts, counters=0, previously stored data at 0x10 still reads back 0xAABBCCDD.
REQ-039 Four back-to-back stores to 0x0..0xC -> accepted on 4 consecutive edges; each reads back correctly with LATENCY=1 (resp_valid the cycle after accept).
